spi_slave_ctrl: RTL and testbench

SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

---
 rtl/spi_slave_ctrl.sv | 129 ++++++++++++
 tb/tb_spi_slave_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_ctrl.sv
// SPI slave command controller: decodes a cmd byte, then register writes or 1-cycle-latency readback; tx_valid holds until tx_ready.
// Optional SPI_AUTOINC_EN: address steps +1 (wrapping) after each write strobe / consumed read byte; otherwise fixed per frame.
module spi_slave_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_en,
  input  logic       ss,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       spi_write,
  output logic [5:0] spi_addr,
  output logic [7:0] spi_wdata,
  input  logic [7:0] spi_rdata,
  output logic       status_clr,
  output logic       err,
  output logic       busy
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WRITE, S_READ, S_DROP} state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_abort;
  logic       w_rd_take;
  logic [5:0] w_addr_next;
  logic [5:0] r_addr;
  logic       r_tx_valid;
  logic [7:0] r_tx_data;
  logic       r_spi_write;
  logic [7:0] r_wdata;
  logic       r_status_clr;
  logic       r_err;

  // Dropping enable mid-frame is treated exactly like the host deselecting.
  assign w_abort   = ~ss | ~spi_en;
  assign w_rd_take = (r_state == S_READ) & r_tx_valid & tx_ready;

`ifdef SPI_AUTOINC_EN
  assign w_addr_next = r_addr + 6'd1;
`else
  assign w_addr_next = r_addr;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (r_state == S_IDLE) begin
      if (ss && spi_en) w_next = S_CMD;
    end else if (w_abort) begin
      w_next = S_IDLE;
    end else if (r_state == S_CMD && rx_valid) begin
      case (rx_data[7:6])
        2'b00:   w_next = S_WRITE;
        2'b10:   w_next = S_READ;
        default: w_next = S_DROP;
      endcase
    end
  end

  always_comb begin
    busy       = (r_state != S_IDLE);
    tx_valid   = r_tx_valid;
    tx_data    = r_tx_data;
    spi_write  = r_spi_write;
    spi_addr   = r_addr;
    spi_wdata  = r_wdata;
    status_clr = r_status_clr;
    err        = r_err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr       <= 6'd0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= 8'd0;
      r_spi_write  <= 1'b0;
      r_wdata      <= 8'd0;
      r_status_clr <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_spi_write  <= 1'b0;
      r_status_clr <= 1'b0;
      if (r_state == S_IDLE || w_abort) begin
        r_addr     <= 6'd0;
        r_tx_valid <= 1'b0;
      end else begin
        case (r_state)
          S_CMD: begin
            if (rx_valid) begin
              r_addr <= rx_data[5:0];
              if (rx_data[6]) r_err <= 1'b1;
            end
          end
          S_WRITE: begin
            // Address steps only after the strobe has been presented at the old address.
            if (r_spi_write) r_addr <= w_addr_next;
            if (rx_valid) begin
              r_spi_write <= 1'b1;
              r_wdata     <= rx_data;
            end
          end
          S_READ: begin
            if (w_rd_take) begin
              r_tx_valid   <= 1'b0;
              r_addr       <= w_addr_next;
              r_status_clr <= (r_addr == 6'd1);
            end else if (!r_tx_valid) begin
              r_tx_data  <= spi_rdata;
              r_tx_valid <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Scoreboarded bench for spi_slave_ctrl: expected writes/reads/status pulses are queued by the stimulus and popped by a monitor.
module tb_spi_slave_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_en;
  logic       ss;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       spi_write;
  logic [5:0] spi_addr;
  logic [7:0] spi_wdata;
  logic [7:0] spi_rdata;
  logic       status_clr;
  logic       err;
  logic       busy;

  logic [7:0]  regs [64];
  logic [13:0] wr_q [$];
  logic [7:0]  rd_q [$];
  bit          st_q [$];
  logic [13:0] mon_w;
  logic [7:0]  mon_r;
  bit          mon_s;
  int          n_cmp = 0;
  int          n_bad = 0;

  spi_slave_ctrl dut (
    .clk(clk), .reset(reset), .spi_en(spi_en), .ss(ss),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .spi_write(spi_write),
    .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
    .status_clr(status_clr), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;
  assign spi_rdata = regs[spi_addr];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got 0x%0h with nothing expected", nm, act);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (spi_write) begin
        if (wr_q.size() == 0) unexpected("write_unexp", 32'({spi_addr, spi_wdata}));
        else begin
          mon_w = wr_q.pop_front();
          check("write_addr_data", 32'({spi_addr, spi_wdata}), 32'(mon_w));
        end
      end
      if (tx_valid && tx_ready) begin
        if (rd_q.size() == 0) unexpected("read_unexp", 32'(tx_data));
        else begin
          mon_r = rd_q.pop_front();
          check("read_data", 32'(tx_data), 32'(mon_r));
        end
      end
      if (status_clr) begin
        if (st_q.size() == 0) unexpected("status_clr_unexp", 32'(spi_addr));
        else begin
          mon_s = st_q.pop_front();
          check("status_clr", 32'(status_clr), 32'(mon_s));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic frame_start();
    ss = 1'b1;
    tick();
  endtask

  task automatic frame_end();
    ss = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_txv(input string nm);
    int k;
    k = 0;
    while (!tx_valid && k < 20) begin
      tick();
      k++;
    end
    if (!tx_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: tx_valid 0 after 20 cycles, required 1", nm);
    end
  endtask

  task automatic consume(input string nm);
    wait_txv(nm);
    if (tx_valid) begin
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      tick();
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({tx_valid, tx_data, spi_write, spi_addr, spi_wdata, status_clr, err, busy});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) regs[i] = 8'hEE;
    regs[0]  = 8'h3C;
    regs[1]  = 8'h01;
    regs[63] = 8'hC3;
    reset = 1'b1; spi_en = 1'b0; ss = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    repeat (3) tick();
    check("reset_outputs", all_outs(), 32'd0);
    reset = 1'b0;
    tick();

    // Disabled block ignores select.
    ss = 1'b1;
    repeat (3) tick();
    check("disabled_busy", 32'(busy), 32'd0);
    ss = 1'b0; spi_en = 1'b1;
    tick();

    // Write burst.
    frame_start();
    check("cmd_busy", 32'(busy), 32'd1);
    wr_q.push_back({6'd5, 8'hAA});
`ifdef SPI_AUTOINC_EN
    wr_q.push_back({6'd6, 8'hBB});
`else
    wr_q.push_back({6'd5, 8'hBB});
`endif
    send(8'h05); send(8'hAA); send(8'hBB);
    frame_end();
    check("wr_end_busy", 32'(busy), 32'd0);
    check("wr_end_addr", 32'(spi_addr), 32'd0);

    // Status read with latency and dummy byte.
    frame_start();
    rd_q.push_back(8'h01);
    st_q.push_back(1'b1);
    rx_data = 8'h81; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("rd_lat0_txv", 32'(tx_valid), 32'd0);
    check("rd_addr", 32'(spi_addr), 32'd1);
    tick();
    check("rd_lat1_txv", 32'(tx_valid), 32'd1);
    check("rd_lat1_data", 32'(tx_data), 32'h01);
    send(8'h22);
    check("rd_dummy_txv", 32'(tx_valid), 32'd1);
    consume("rd_status");
    repeat (2) tick();
    frame_end();

    // Address wrap.
    frame_start();
    rd_q.push_back(8'hC3);
`ifdef SPI_AUTOINC_EN
    rd_q.push_back(8'h3C);
`else
    rd_q.push_back(8'hC3);
`endif
    send(8'hBF);
    consume("wrap_0");
    consume("wrap_1");
    frame_end();

    // Illegal opcode, sticky error.
    frame_start();
    send(8'h45);
    check("illegal_err", 32'(err), 32'd1);
    check("drop_busy", 32'(busy), 32'd1);
    send(8'h11);
    frame_end();
    check("err_after_frame", 32'(err), 32'd1);
    frame_start();
    wr_q.push_back({6'd3, 8'h77});
    send(8'h03); send(8'h77);
    frame_end();
    check("err_next_frame", 32'(err), 32'd1);

    // Abort on coincident data byte.
    frame_start();
    send(8'h0A);
    rx_data = 8'h99; rx_valid = 1'b1; ss = 1'b0;
    tick();
    rx_valid = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_addr", 32'(spi_addr), 32'd0);
    repeat (2) tick();

    // Enable drop mid-frame.
    frame_start();
    send(8'h10);
    rx_data = 8'h66; rx_valid = 1'b1; spi_en = 1'b0;
    tick();
    rx_valid = 1'b0;
    check("en_drop_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    check("en_low_stay_idle", 32'(busy), 32'd0);
    ss = 1'b0; spi_en = 1'b1;
    tick();

    // Reset mid-read.
    frame_start();
    send(8'h81);
    wait_txv("rst_mid_read");
    check("pre_reset_txv", 32'(tx_valid), 32'd1);
    check("pre_reset_err", 32'(err), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("reset_mid_read_outs", all_outs(), 32'd0);
    ss = 1'b0;
    tick();
    reset = 1'b0;
    repeat (2) tick();
    check("err_cleared", 32'(err), 32'd0);
    check("idle_after_reset", 32'(busy), 32'd0);

    repeat (5) tick();
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);
    check("st_q_drained", 32'(st_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
